// File: rtl/shift_normalizer_8_pkg.sv
// Purpose : shared types and constants for the shift normalizer slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default WIDTH/AMT_W, direction encodings.
package shift_normalizer_8_pkg;

    // Default geometry: AMT_W must equal log2(WIDTH).
    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 3;

    // Direction encodings: left drives the MSB to 1, right drives the LSB to 1.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_normalizer_8_pkg

// File: rtl/shift_normalizer_8_shift_step_1.sv
// Purpose : one-position bidirectional logical shift, zero fill, no rotate.
// Latency : combinational (0 cycles).
// Backpressure: none; pure function of d and dir.
// Ports   : d (word in), dir (0 = toward MSB, 1 = toward LSB), q (shifted word).

// Elementary 2:1 mux cell: y = sel ? b : a.
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule : mux2_cell

module shift_step_1
    import shift_normalizer_8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    // Candidate source bit for each output position in either direction.
    // The vacated end is filled with zero, so shifts are strictly logical.
    logic [WIDTH-1:0] left_src;
    logic [WIDTH-1:0] right_src;

    assign left_src  = {d[WIDTH-2:0], 1'b0};
    assign right_src = {1'b0, d[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_cell u_mux (
            .a   (left_src[i]),
            .b   (right_src[i]),
            .sel (dir),
            .y   (q[i])
        );
    end

endmodule : shift_step_1

// File: rtl/shift_normalizer_8.sv
// Purpose : sequential normalizer; shifts a word one bit per cycle until the
//           target end bit (MSB for left, LSB for right) is 1.
// Latency : k+1 cycles after accept for k shifts; zero input done on accept.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
// Ports   : clk/rst_n (sync active-low); in_valid/in_ready/in_data/in_dir
//           request side; out_valid/out_ready/out_data/out_amt/out_zero result.
module shift_normalizer_8
    import shift_normalizer_8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_zero
);

    state_t           state;
    state_t           state_nxt;

    // The working register doubles as the result register: once the target
    // bit is 1 it is simply left alone, so DONE holds it without extra flops.
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic [AMT_W-1:0] amt;
    logic             zero;
    logic             dir;

    logic             accept;
    logic             target_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign target_bit = (dir == DIR_RIGHT) ? work[0] : work[WIDTH-1];

    assign out_data = work;
    assign out_amt  = amt;
    assign out_zero = zero;

    shift_step_1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .d   (work),
        .dir (dir),
        .q   (work_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // An all-zero word can never reach the target bit, so it
                    // bypasses SHIFT and is reported via out_zero instead.
                    state_nxt = (in_data == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (target_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: loads on accept, steps in SHIFT, otherwise holds.
    // amt cannot wrap: a nonzero word hits the target bit within WIDTH-1 steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work <= '0;
            amt  <= '0;
            zero <= 1'b0;
            dir  <= DIR_LEFT;
        end else if (accept) begin
            work <= in_data;
            amt  <= '0;
            zero <= (in_data == '0);
            dir  <= in_dir;
        end else if ((state == SHIFT) && !target_bit) begin
            work <= work_step;
            amt  <= amt + AMT_W'(1);
        end
    end

endmodule : shift_normalizer_8
